// File: rtl/pwm_deadtime_channel_pkg.sv
// rtl/pwm_deadtime_channel_pkg.sv - shared FSM state encoding and pin polarity helper
package pwm_deadtime_channel_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE         = 3'd0,
    LOW_ON       = 3'd1,
    DEAD_TO_HIGH = 3'd2,
    HIGH_ON      = 3'd3,
    DEAD_TO_LOW  = 3'd4
  } pwm_state_t;

  // Maps a logical "pin asserted" onto the physical pin level.
  function automatic logic pin_level(input logic active, input logic active_low);
    return active ^ active_low;
  endfunction

endpackage

// File: rtl/pwm_deadtime_fsm.sv
// rtl/pwm_deadtime_fsm.sv - complementary pin state machine with dead-time insertion
module pwm_deadtime_fsm
  import pwm_deadtime_channel_pkg::*;
#(
  parameter int DT_WIDTH   = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                raw,
  input  logic [DT_WIDTH-1:0] deadtime,
  output logic                pwm_high,
  output logic                pwm_low
);

  localparam logic [DT_WIDTH-1:0] DT_ONE = 1;

  pwm_state_t          state, state_next;
  logic [DT_WIDTH-1:0] dt_count, dt_count_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      dt_count <= '0;
      pwm_high <= pin_level(1'b0, ACTIVE_LOW);
      pwm_low  <= pin_level(1'b0, ACTIVE_LOW);
    end else begin
      state    <= state_next;
      dt_count <= dt_count_next;
      pwm_high <= pin_level(state_next == HIGH_ON, ACTIVE_LOW);
      pwm_low  <= pin_level(state_next == LOW_ON, ACTIVE_LOW);
    end
  end

  // The counter is loaded with N-1 on entry so a setting of N yields N dead cycles.
  always_comb begin
    state_next    = state;
    dt_count_next = (dt_count != '0) ? dt_count - DT_ONE : '0;
    case (state)
      IDLE, LOW_ON: begin
        if (raw) begin
          if (deadtime == '0) begin
            state_next = HIGH_ON;
          end else begin
            state_next    = DEAD_TO_HIGH;
            dt_count_next = deadtime - DT_ONE;
          end
        end else begin
          state_next = LOW_ON;
        end
      end
      DEAD_TO_HIGH: begin
        if (!raw) state_next = LOW_ON;
        else if (dt_count == '0) state_next = HIGH_ON;
      end
      HIGH_ON: begin
        if (!raw) begin
          if (deadtime == '0) begin
            state_next = LOW_ON;
          end else begin
            state_next    = DEAD_TO_LOW;
            dt_count_next = deadtime - DT_ONE;
          end
        end
      end
      DEAD_TO_LOW: begin
        if (raw) state_next = HIGH_ON;
        else if (dt_count == '0) state_next = LOW_ON;
      end
      default: state_next = IDLE;
    endcase
    if (!enable) state_next = IDLE;
  end

endmodule

// File: rtl/pwm_deadtime_channel.sv
// rtl/pwm_deadtime_channel.sv - double-buffered compare channel driving a complementary PWM pair
module pwm_deadtime_channel
  import pwm_deadtime_channel_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DT_WIDTH   = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [WIDTH-1:0]    counter_value,
  input  logic [WIDTH-1:0]    compare_in,
  input  logic                compare_load,
  input  logic [DT_WIDTH-1:0] deadtime_in,
  input  logic                deadtime_load,
  output logic [WIDTH-1:0]    compare_active,
  output logic                pwm_high,
  output logic                pwm_low,
  output logic                period_event,
  output logic                compare_event
);

  logic [WIDTH-1:0]    prev_value;
  logic [WIDTH-1:0]    compare_shadow;
  logic [DT_WIDTH-1:0] deadtime_shadow;
  logic [DT_WIDTH-1:0] deadtime_active;
  logic                enable_d;
  logic                raw;
  logic                raw_d;
  logic                wrap;
  logic                load;

  // Edge-based wrap so a prescaled counter sitting at 0 only counts once.
  assign wrap = enable && (counter_value == '0) && (prev_value != '0);
  assign load = wrap || (enable && !enable_d);
  assign raw  = enable && (counter_value < compare_active);

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_value      <= '0;
      enable_d        <= 1'b0;
      raw_d           <= 1'b0;
      compare_shadow  <= '0;
      compare_active  <= '0;
      deadtime_shadow <= '0;
      deadtime_active <= '0;
      period_event    <= 1'b0;
      compare_event   <= 1'b0;
    end else begin
      prev_value <= counter_value;
      enable_d   <= enable;
      raw_d      <= raw;
      if (compare_load) compare_shadow <= compare_in;
      if (deadtime_load) deadtime_shadow <= deadtime_in;
      // A strobe landing on the load point bypasses the shadow.
      if (load) begin
        compare_active  <= compare_load ? compare_in : compare_shadow;
        deadtime_active <= deadtime_load ? deadtime_in : deadtime_shadow;
      end
      period_event  <= wrap;
      compare_event <= enable && raw_d && !raw;
    end
  end

  pwm_deadtime_fsm #(
    .DT_WIDTH  (DT_WIDTH),
    .ACTIVE_LOW(ACTIVE_LOW)
  ) u_fsm (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .raw     (raw),
    .deadtime(deadtime_active),
    .pwm_high(pwm_high),
    .pwm_low (pwm_low)
  );

endmodule

// File: tb/tb_pwm_deadtime_channel.sv
// tb/tb_pwm_deadtime_channel.sv - randomized and directed bench for pwm_deadtime_channel
module tb_pwm_deadtime_channel;

  localparam int WIDTH    = 8;
  localparam int DT_WIDTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst = 1'b1;
  logic                enable = 1'b0;
  logic [WIDTH-1:0]    counter_value = '0;
  logic [WIDTH-1:0]    compare_in = '0;
  logic                compare_load = 1'b0;
  logic [DT_WIDTH-1:0] deadtime_in = '0;
  logic                deadtime_load = 1'b0;
  logic [WIDTH-1:0]    compare_active;
  logic                pwm_high, pwm_low, period_event, compare_event;

  pwm_deadtime_channel #(.WIDTH(WIDTH), .DT_WIDTH(DT_WIDTH), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .enable(enable), .counter_value(counter_value),
    .compare_in(compare_in), .compare_load(compare_load),
    .deadtime_in(deadtime_in), .deadtime_load(deadtime_load),
    .compare_active(compare_active), .pwm_high(pwm_high), .pwm_low(pwm_low),
    .period_event(period_event), .compare_event(compare_event)
  );

  int checks = 0;
  int failures = 0;
  int cnt = 0;
  int top = 9;
  bit hold = 0;

  // Reference model: register-level load rules, pins from run lengths of raw.
  logic [WIDTH-1:0]    m_prev, m_cmp_sh, m_cmp_act;
  logic [DT_WIDTH-1:0] m_dt_sh, m_dt_act;
  bit m_en_d, m_raw_d, m_owner_high, m_run_raw;
  int m_run, m_run_dt;
  bit exp_high, exp_low, exp_pe, exp_ce;

  task automatic model_step();
    bit raw, wrap, load;
    if (rst) begin
      m_prev = '0; m_cmp_sh = '0; m_cmp_act = '0; m_dt_sh = '0; m_dt_act = '0;
      m_en_d = 0; m_raw_d = 0; m_owner_high = 0; m_run = 0; m_run_raw = 0; m_run_dt = 0;
      exp_high = 0; exp_low = 0; exp_pe = 0; exp_ce = 0;
    end else begin
      raw  = enable && (counter_value < m_cmp_act);
      wrap = enable && (counter_value == 0) && (m_prev != 0);
      load = wrap || (enable && !m_en_d);
      if (!enable) begin
        exp_high = 0; exp_low = 0; m_owner_high = 0; m_run = 0;
      end else begin
        if (m_run == 0 || raw != m_run_raw) begin
          m_run = 1; m_run_raw = raw; m_run_dt = int'(m_dt_act);
        end else begin
          m_run++;
        end
        if (raw != m_owner_high && m_run > m_run_dt) m_owner_high = raw;
        exp_high = (raw == m_owner_high) && raw;
        exp_low  = (raw == m_owner_high) && !raw;
      end
      exp_pe = wrap;
      exp_ce = enable && m_raw_d && !raw;
      m_raw_d = raw;
      if (load) begin
        m_cmp_act = compare_load ? compare_in : m_cmp_sh;
        m_dt_act  = deadtime_load ? deadtime_in : m_dt_sh;
      end
      if (compare_load) m_cmp_sh = compare_in;
      if (deadtime_load) m_dt_sh = deadtime_in;
      m_prev = counter_value;
      m_en_d = enable;
    end
  endtask

  task automatic tick();
    counter_value = WIDTH'(cnt);
    @(posedge clk);
    model_step();
    #1;
    compare_load  = 1'b0;
    deadtime_load = 1'b0;
    if (!hold) cnt = (cnt >= top) ? 0 : cnt + 1;
  endtask

  task automatic align();
    for (int i = 0; i < 300 && cnt != 0; i++) tick();
  endtask

  // One counter period starting at cnt==0; optional compare strobe at index strobe_at.
  task automatic run_period(input int strobe_at, input logic [WIDTH-1:0] val,
                            output int hi, output int lo, output int gap,
                            output int both, output int pe, output int ce);
    hi = 0; lo = 0; gap = 0; both = 0; pe = 0; ce = 0;
    for (int k = 0; k <= top; k++) begin
      if (k == strobe_at) begin
        compare_in = val;
        compare_load = 1'b1;
      end
      tick();
      hi += int'(pwm_high);
      lo += int'(pwm_low);
      gap += int'(!pwm_high && !pwm_low);
      both += int'(pwm_high && pwm_low);
      pe += int'(period_event);
      ce += int'(compare_event);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      compare_in = WIDTH'($urandom_range(1, 200));
      compare_load = 1'b1;
      tick();
      checks++;
      if ({pwm_high, pwm_low, period_event, compare_event} !== 4'b0000 || compare_active !== '0) begin
        failures++;
        $display("FAIL reset cyc=%0d got h=%b l=%b pe=%b ce=%b cmp=%0d want all zero",
                 i, pwm_high, pwm_low, period_event, compare_event, compare_active);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int hi, lo, gap, both, pe, ce;
    enable = 1'b0;
    tick();
    compare_in = 8'd4; compare_load = 1'b1;
    deadtime_in = 4'd0; deadtime_load = 1'b1;
    tick();
    align();
    enable = 1'b1;
    run_period(-1, '0, hi, lo, gap, both, pe, ce);
    run_period(-1, '0, hi, lo, gap, both, pe, ce);
    checks++;
    if (hi !== 4 || lo !== 6 || gap !== 0 || both !== 0 || pe !== 1 || ce !== 1) begin
      failures++;
      $display("FAIL basic got hi=%0d lo=%0d gap=%0d both=%0d pe=%0d ce=%0d want 4 6 0 0 1 1",
               hi, lo, gap, both, pe, ce);
    end
  endtask

  task automatic test_deadtime();
    int hi, lo, gap, both, pe, ce;
    deadtime_in = 4'd2; deadtime_load = 1'b1;
    run_period(-1, '0, hi, lo, gap, both, pe, ce);
    run_period(-1, '0, hi, lo, gap, both, pe, ce);
    checks++;
    if (hi !== 2 || lo !== 4 || gap !== 4 || both !== 0) begin
      failures++;
      $display("FAIL deadtime got hi=%0d lo=%0d gap=%0d both=%0d want 2 4 4 0", hi, lo, gap, both);
    end
  endtask

  task automatic test_short_abort();
    int hi, lo, gap, both, pe, ce;
    deadtime_in = 4'd3; deadtime_load = 1'b1;
    run_period(0, 8'd1, hi, lo, gap, both, pe, ce);
    run_period(-1, '0, hi, lo, gap, both, pe, ce);
    checks++;
    if (hi !== 0 || lo !== 9 || gap !== 1 || ce !== 1 || pe !== 1) begin
      failures++;
      $display("FAIL short_abort got hi=%0d lo=%0d gap=%0d ce=%0d pe=%0d want 0 9 1 1 1",
               hi, lo, gap, ce, pe);
    end
  endtask

  task automatic test_double_buffer();
    int hi, lo, gap, both, pe, ce;
    deadtime_in = 4'd0; deadtime_load = 1'b1;
    run_period(0, 8'd4, hi, lo, gap, both, pe, ce);
    run_period(3, 8'd7, hi, lo, gap, both, pe, ce);
    checks++;
    if (hi !== 4 || compare_active !== 8'd4) begin
      failures++;
      $display("FAIL dbuf_hold got hi=%0d cmp=%0d want 4 4", hi, compare_active);
    end
    run_period(-1, '0, hi, lo, gap, both, pe, ce);
    checks++;
    if (hi !== 7 || compare_active !== 8'd7) begin
      failures++;
      $display("FAIL dbuf_next got hi=%0d cmp=%0d want 7 7", hi, compare_active);
    end
    run_period(0, 8'd2, hi, lo, gap, both, pe, ce);
    checks++;
    if (hi !== 2 || compare_active !== 8'd2) begin
      failures++;
      $display("FAIL dbuf_bypass got hi=%0d cmp=%0d want 2 2", hi, compare_active);
    end
  endtask

  task automatic test_extremes();
    int hi, lo, gap, both, pe, ce;
    run_period(0, 8'd0, hi, lo, gap, both, pe, ce);
    run_period(-1, '0, hi, lo, gap, both, pe, ce);
    checks++;
    if (hi !== 0 || lo !== 10 || gap !== 0 || ce !== 0) begin
      failures++;
      $display("FAIL cmp_zero got hi=%0d lo=%0d gap=%0d ce=%0d want 0 10 0 0", hi, lo, gap, ce);
    end
    run_period(0, 8'd10, hi, lo, gap, both, pe, ce);
    run_period(-1, '0, hi, lo, gap, both, pe, ce);
    checks++;
    if (hi !== 10 || lo !== 0 || gap !== 0) begin
      failures++;
      $display("FAIL cmp_over_top got hi=%0d lo=%0d gap=%0d want 10 0 0", hi, lo, gap);
    end
    enable = 1'b0;
    tick();
    checks++;
    if (pwm_high !== 1'b0 || pwm_low !== 1'b0) begin
      failures++;
      $display("FAIL disable got h=%b l=%b want 0 0", pwm_high, pwm_low);
    end
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 6; seg++) begin
      top = $urandom_range(3, 20);
      for (int i = 0; i < 300; i++) begin
        hold = ($urandom_range(0, 3) == 0);
        rst = ($urandom_range(0, 299) == 0);
        if ($urandom_range(0, 39) == 0) enable = !enable;
        if ($urandom_range(0, 7) == 0) begin
          compare_in = WIDTH'($urandom_range(0, top + 2));
          compare_load = 1'b1;
        end
        if ($urandom_range(0, 7) == 0) begin
          deadtime_in = DT_WIDTH'($urandom_range(0, 15));
          deadtime_load = 1'b1;
        end
        tick();
        checks++;
        if ({pwm_high, pwm_low, period_event, compare_event} !== {exp_high, exp_low, exp_pe, exp_ce}
            || compare_active !== m_cmp_act) begin
          failures++;
          $display("FAIL random seg=%0d cyc=%0d got h=%b l=%b pe=%b ce=%b cmp=%0d want h=%b l=%b pe=%b ce=%b cmp=%0d",
                   seg, i, pwm_high, pwm_low, period_event, compare_event, compare_active,
                   exp_high, exp_low, exp_pe, exp_ce, m_cmp_act);
        end
        checks++;
        if (pwm_high && pwm_low) begin
          failures++;
          $display("FAIL overlap seg=%0d cyc=%0d got h=%b l=%b want never both", seg, i, pwm_high, pwm_low);
        end
      end
    end
    rst = 1'b0;
    hold = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_deadtime();
    test_short_abort();
    test_double_buffer();
    test_extremes();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
